// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key event decoder: prefix FSM states,
// scancode prefix bytes, the decoded event record and the Pause-sequence skip length.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0,
    ST_PAUSE
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BRK        = 8'hF0;
  localparam logic [7:0] PS2_PAUSE      = 8'hE1;
  localparam logic [7:0] PS2_FAKE_SHIFT = 8'h12;
  localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  // Keyboard status/ack bytes that never start or complete a key event.
  function automatic logic ps2_is_ignored(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous event FIFO with same-cycle push/pop; a push into a full FIFO is
// accepted only when a pop happens on the same edge, otherwise it sets a sticky overflow.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  ps2_event_t i_push_dat,
  input  logic       i_pop,
  output ps2_event_t o_head_dat,
  output logic       o_empty,
  output logic       o_full,
  output logic       o_overflow
);

  localparam int AW = $clog2(DEPTH);

  ps2_event_t r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        r_overflow;
  logic        w_pop;
  logic        w_accept;

  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop      = i_pop && !o_empty;
  assign w_accept   = i_push && (!o_full || w_pop);
  assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];
  assign o_overflow = r_overflow;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_accept) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && !w_accept) r_overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// Decodes PS/2 scancode bytes into make/break events (FIFO-buffered, 2-cycle latency) and
// tracks held keys; define PS2_TYPEMATIC_FILTER_EN to drop repeat makes of already-held keys.
module ps2_key_event_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_KEYS   = 4
) (
  input  logic                            CLOCK_50,
  input  logic                            reset,
  input  logic [7:0]                      received_data,
  input  logic                            received_data_en,
  input  logic                            ev_ready,
  output logic                            ev_valid,
  output logic [7:0]                      ev_code,
  output logic                            ev_ext,
  output logic                            ev_break,
  output logic                            fifo_overflow,
  output logic [MAX_KEYS-1:0]             held_valid,
  output logic [9*MAX_KEYS-1:0]           held_keys,
  output logic [$clog2(MAX_KEYS+1)-1:0]   held_count
);

  localparam int KW = (MAX_KEYS > 1) ? $clog2(MAX_KEYS) : 1;
  localparam int CW = $clog2(MAX_KEYS + 1);

  ps2_state_t            r_state, w_state_nxt;
  logic [2:0]            r_skip, w_skip_nxt;
  logic                  r_ev_vld, w_emit;
  ps2_event_t            r_ev, w_emit_ev;
  logic [MAX_KEYS-1:0]   r_held_valid, w_valid_nxt;
  logic [9*MAX_KEYS-1:0] r_held_keys, w_keys_nxt;
  logic [CW-1:0]         r_held_count, w_count_nxt;
  logic [8:0]            w_key;
  logic                  w_hit, w_free, w_push, w_empty, w_full;
  logic [KW-1:0]         w_hit_idx, w_free_idx;
  ps2_event_t            w_head;

  always_comb begin
    w_state_nxt = r_state;
    w_skip_nxt  = r_skip;
    w_emit      = 1'b0;
    w_emit_ev   = '{ext: 1'b0, brk: 1'b0, code: received_data};
    if (received_data_en) begin
      case (r_state)
        ST_IDLE: begin
          if (received_data == PS2_EXT)        w_state_nxt = ST_E0;
          else if (received_data == PS2_BRK)   w_state_nxt = ST_F0;
          else if (received_data == PS2_PAUSE) begin
            w_state_nxt = ST_PAUSE;
            w_skip_nxt  = PS2_PAUSE_SKIP;
          end else if (!ps2_is_ignored(received_data)) w_emit = 1'b1;
        end
        ST_E0: begin
          if (received_data == PS2_BRK)             w_state_nxt = ST_E0F0;
          else if (received_data == PS2_EXT)        w_state_nxt = ST_E0;
          else if (received_data == PS2_FAKE_SHIFT) w_state_nxt = ST_IDLE;
          else begin
            w_emit        = 1'b1;
            w_emit_ev.ext = 1'b1;
            w_state_nxt   = ST_IDLE;
          end
        end
        ST_F0: begin
          if (received_data != PS2_BRK) begin
            w_emit        = 1'b1;
            w_emit_ev.brk = 1'b1;
            w_state_nxt   = ST_IDLE;
          end
        end
        ST_E0F0: begin
          w_state_nxt = ST_IDLE;
          if (received_data != PS2_FAKE_SHIFT) begin
            w_emit        = 1'b1;
            w_emit_ev.ext = 1'b1;
            w_emit_ev.brk = 1'b1;
          end
        end
        ST_PAUSE: begin
          w_skip_nxt = r_skip - 3'd1;
          if (r_skip <= 3'd1) begin
            w_state_nxt = ST_IDLE;
            w_skip_nxt  = '0;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Held-table lookup for the registered event; the free search runs high-to-low so the lowest slot wins.
  assign w_key = {r_ev.ext, r_ev.code};

  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = 0; i < MAX_KEYS; i++) begin
      if (r_held_valid[i] && (r_held_keys[9*i +: 9] == w_key)) begin
        w_hit     = 1'b1;
        w_hit_idx = KW'(i);
      end
    end
    for (int i = MAX_KEYS - 1; i >= 0; i--) begin
      if (!r_held_valid[i]) begin
        w_free     = 1'b1;
        w_free_idx = KW'(i);
      end
    end
    w_valid_nxt = r_held_valid;
    w_keys_nxt  = r_held_keys;
    if (r_ev_vld) begin
      if (r_ev.brk) begin
        if (w_hit) begin
          w_valid_nxt[w_hit_idx]        = 1'b0;
          w_keys_nxt[9*w_hit_idx +: 9]  = '0;
        end
      end else if (!w_hit && w_free) begin
        w_valid_nxt[w_free_idx]       = 1'b1;
        w_keys_nxt[9*w_free_idx +: 9] = w_key;
      end
    end
    w_count_nxt = '0;
    for (int i = 0; i < MAX_KEYS; i++) w_count_nxt = w_count_nxt + CW'(w_valid_nxt[i]);
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  assign w_push = r_ev_vld && (r_ev.brk || !w_hit);
`else
  assign w_push = r_ev_vld;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_skip       <= '0;
      r_ev_vld     <= 1'b0;
      r_ev         <= '0;
      r_held_valid <= '0;
      r_held_keys  <= '0;
      r_held_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_skip       <= w_skip_nxt;
      r_ev_vld     <= w_emit;
      r_ev         <= w_emit_ev;
      r_held_valid <= w_valid_nxt;
      r_held_keys  <= w_keys_nxt;
      r_held_count <= w_count_nxt;
    end
  end

  ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk      (CLOCK_50),
    .i_rst      (reset),
    .i_push     (w_push),
    .i_push_dat (r_ev),
    .i_pop      (ev_valid && ev_ready),
    .o_head_dat (w_head),
    .o_empty    (w_empty),
    .o_full     (w_full),
    .o_overflow (fifo_overflow)
  );

  assign ev_valid   = !w_empty;
  assign ev_code    = w_head.code;
  assign ev_ext     = w_head.ext;
  assign ev_break   = w_head.brk;
  assign held_valid = r_held_valid;
  assign held_keys  = r_held_keys;
  assign held_count = r_held_count;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Bench for ps2_key_event_decoder: directed scancode sequences with literal expectations,
// then randomized bytes, each cycle compared against a queue/array reference model.
module tb_ps2_key_event_decoder;

  localparam int DEPTH = 8;
  localparam int NK    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_dat = 8'h00;
  logic              rx_en = 1'b0;
  logic              rdy = 1'b0;
  logic              ev_valid, ev_ext, ev_break, fifo_overflow;
  logic [7:0]        ev_code;
  logic [NK-1:0]     held_valid;
  logic [9*NK-1:0]   held_keys;
  logic [2:0]        held_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ps2_key_event_decoder #(.FIFO_DEPTH(DEPTH), .MAX_KEYS(NK)) dut (
    .CLOCK_50         (clk),
    .reset            (rst),
    .received_data    (rx_dat),
    .received_data_en (rx_en),
    .ev_ready         (rdy),
    .ev_valid         (ev_valid),
    .ev_code          (ev_code),
    .ev_ext           (ev_ext),
    .ev_break         (ev_break),
    .fifo_overflow    (fifo_overflow),
    .held_valid       (held_valid),
    .held_keys        (held_keys),
    .held_count       (held_count)
  );

  typedef struct {
    bit       ext;
    bit       brk;
    bit [7:0] code;
  } ev_t;

  // Reference model: event queue, pending decoded event, key table, prefix flags.
  ev_t      m_q[$];
  bit       m_pend_v;
  ev_t      m_pend;
  bit       m_ovf;
  bit       m_hv [NK];
  bit [8:0] m_key [NK];
  bit       m_e0, m_f0;
  int       m_skip;
  bit       cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit ignored(input bit [7:0] b);
    return b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA || b == 8'hFE || b == 8'hFF;
  endfunction

  function automatic void emit(input bit ext, input bit brk, input bit [7:0] code);
    m_pend_v    = 1'b1;
    m_pend.ext  = ext;
    m_pend.brk  = brk;
    m_pend.code = code;
    m_e0 = 1'b0;
    m_f0 = 1'b0;
  endfunction

  // Advance the model by one clock edge, using the inputs that were present at that edge.
  task automatic model_step();
    bit       popd;
    bit       push;
    int       pre, hit, free_i;
    bit [8:0] k;
    if (rst) begin
      m_q.delete();
      m_pend_v = 1'b0;
      m_ovf = 1'b0;
      m_e0 = 1'b0;
      m_f0 = 1'b0;
      m_skip = 0;
      for (int i = 0; i < NK; i++) begin
        m_hv[i]  = 1'b0;
        m_key[i] = '0;
      end
    end else begin
      pre  = m_q.size();
      popd = (pre > 0) && rdy;
      if (popd) void'(m_q.pop_front());
      if (m_pend_v) begin
        k = {m_pend.ext, m_pend.code};
        hit = -1;
        free_i = -1;
        for (int i = 0; i < NK; i++) if (m_hv[i] && m_key[i] == k && hit < 0) hit = i;
        for (int i = NK - 1; i >= 0; i--) if (!m_hv[i]) free_i = i;
        push = 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
        if (!m_pend.brk && hit >= 0) push = 1'b0;
`endif
        if (push) begin
          if (pre < DEPTH || popd) m_q.push_back(m_pend);
          else m_ovf = 1'b1;
        end
        if (m_pend.brk) begin
          if (hit >= 0) m_hv[hit] = 1'b0;
        end else if (hit < 0 && free_i >= 0) begin
          m_hv[free_i]  = 1'b1;
          m_key[free_i] = k;
        end
      end
      m_pend_v = 1'b0;
      if (rx_en) begin
        if (m_skip > 0) m_skip--;
        else if (!m_e0 && !m_f0) begin
          if (rx_dat == 8'hE0) m_e0 = 1'b1;
          else if (rx_dat == 8'hF0) m_f0 = 1'b1;
          else if (rx_dat == 8'hE1) m_skip = 7;
          else if (!ignored(rx_dat)) emit(1'b0, 1'b0, rx_dat);
        end else if (m_e0 && !m_f0) begin
          if (rx_dat == 8'hF0) m_f0 = 1'b1;
          else if (rx_dat == 8'h12) m_e0 = 1'b0;
          else if (rx_dat != 8'hE0) emit(1'b1, 1'b0, rx_dat);
        end else if (!m_e0) begin
          if (rx_dat != 8'hF0) emit(1'b0, 1'b1, rx_dat);
        end else begin
          if (rx_dat != 8'h12) emit(1'b1, 1'b1, rx_dat);
          m_e0 = 1'b0;
          m_f0 = 1'b0;
        end
      end
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      int cnt;
      cnt = 0;
      chk("ev_valid", ev_valid, m_q.size() > 0);
      if (m_q.size() > 0)
        chk("head_event", {ev_ext, ev_break, ev_code}, {m_q[0].ext, m_q[0].brk, m_q[0].code});
      chk("fifo_overflow", fifo_overflow, m_ovf);
      for (int i = 0; i < NK; i++) begin
        chk("held_valid", held_valid[i], m_hv[i]);
        if (m_hv[i]) chk("held_key", held_keys[9*i +: 9], m_key[i]);
        cnt += int'(m_hv[i]);
      end
      chk("held_count", held_count, cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic send(input logic [7:0] b);
    rx_dat = b;
    rx_en  = 1'b1;
    tick();
    rx_en  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic pop_expect(input string name, input logic [7:0] code, input logic ext, input logic brk);
    chk({name, "_valid"}, ev_valid, 1'b1);
    chk(name, {ev_ext, ev_break, ev_code}, {ext, brk, code});
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
  endtask

  logic [7:0] codes [9];
  logic [7:0] pool  [14];

  initial begin
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    pool  = '{8'hE0, 8'hF0, 8'hF0, 8'hE1, 8'h12, 8'h1C, 8'h1C, 8'h1D, 8'h75,
              8'h15, 8'h00, 8'hAA, 8'h2C, 8'h24};
    tick();
    tick();
    chk("reset_ev", {ev_valid, ev_ext, ev_break, ev_code}, 11'h0);
    chk("reset_ovf", fifo_overflow, 1'b0);
    chk("reset_held", {held_valid, held_keys, held_count}, 43'h0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Plain make then break.
    send(8'h1C);
    tick();
    chk("mk_held_slot0", held_keys[8:0], 9'h01C);
    chk("mk_held_count", held_count, 3'd1);
    send(8'hF0);
    send(8'h1C);
    tick();
    chk("brk_held_count", held_count, 3'd0);
    pop_expect("ev_1c_make", 8'h1C, 1'b0, 1'b0);
    pop_expect("ev_1c_break", 8'h1C, 1'b0, 1'b1);
    chk("drained", ev_valid, 1'b0);

    // Extended make/break.
    send(8'hE0);
    send(8'h75);
    tick();
    chk("ext_held_key", held_keys[8:0], 9'h175);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    tick();
    pop_expect("ev_75_make", 8'h75, 1'b1, 1'b0);
    pop_expect("ev_75_break", 8'h75, 1'b1, 1'b1);
    chk("ext_released", held_valid, 4'h0);

    // Pause sequence emits nothing; following key emits normally.
    foreach (pool[i]) if (i < 0) rx_dat = pool[i];
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h1B);
    tick();
    pop_expect("ev_after_pause", 8'h1B, 1'b0, 1'b0);
    chk("pause_only_one", ev_valid, 1'b0);
    do_reset();

    // Typematic repeats.
    send(8'h1C); send(8'h1C); send(8'h1C);
    tick();
    chk("repeat_count", held_count, 3'd1);
`ifdef PS2_TYPEMATIC_FILTER_EN
    pop_expect("repeat_0", 8'h1C, 1'b0, 1'b0);
`else
    for (int i = 0; i < 3; i++) pop_expect("repeat_n", 8'h1C, 1'b0, 1'b0);
`endif
    chk("repeat_drained", ev_valid, 1'b0);
    do_reset();

    // Overflow: DEPTH+1 makes with no consumer.
    for (int i = 0; i < 9; i++) send(codes[i]);
    tick();
    chk("overflow_set", fifo_overflow, 1'b1);
    for (int i = 0; i < 8; i++) pop_expect("ovf_order", codes[i], 1'b0, 1'b0);
    chk("ovf_drained", ev_valid, 1'b0);
    do_reset();

    // Full FIFO with a pop on the same edge as the extra push.
    for (int i = 0; i < 8; i++) send(codes[i]);
    rx_dat = codes[8];
    rx_en  = 1'b1;
    tick();
    rx_en  = 1'b0;
    rdy    = 1'b1;
    tick();
    rdy    = 1'b0;
    chk("full_pop_no_ovf", fifo_overflow, 1'b0);
    for (int i = 1; i < 9; i++) pop_expect("full_pop_order", codes[i], 1'b0, 1'b0);
    do_reset();

    // Table full, then a freed slot is reused.
    for (int i = 0; i < 5; i++) send(codes[i]);
    tick();
    chk("table_full", held_keys, {9'h02D, 9'h024, 9'h01D, 9'h015});
    chk("table_count", held_count, 3'd4);
    send(8'hF0);
    send(8'h1D);
    send(8'h2C);
    tick();
    chk("slot1_reuse", held_keys[17:9], 9'h02C);
    chk("slot1_valid", held_valid, 4'hF);
    for (int i = 0; i < 5; i++) pop_expect("table_q", codes[i], 1'b0, 1'b0);
    do_reset();

    // Reset discards a pending prefix or a Pause skip.
    send(8'hE0);
    do_reset();
    send(8'h1C);
    tick();
    pop_expect("rst_prefix", 8'h1C, 1'b0, 1'b0);
    send(8'hE1);
    send(8'h14);
    do_reset();
    send(8'h1B);
    tick();
    pop_expect("rst_pause", 8'h1B, 1'b0, 1'b0);

    // Randomized traffic.
    begin
      int pct;
      pct = 60;
      for (int c = 0; c < 4000; c++) begin
        if (c % 250 == 0) pct = (c % 750 == 0) ? 5 : ((c % 500 == 0) ? 100 : 60);
        rdy    = ($urandom_range(0, 99) < pct);
        rx_en  = ($urandom_range(0, 2) != 0);
        rx_dat = pool[$urandom_range(0, 13)];
        rst    = ($urandom_range(0, 599) == 0);
        tick();
      end
      rst   = 1'b0;
      rx_en = 1'b0;
      rdy   = 1'b1;
      for (int c = 0; c < 12; c++) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
